// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared state encoding and default timing constants for the
//               PLL reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        HOLD      = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        SOFT      = 3'd5
    } pll_seq_state_t;

    localparam int c_SYNC_STAGES     = 2;
    localparam int c_PLL_RST_CYCLES  = 16;
    localparam int c_LOCK_TIMEOUT    = 500000;
    localparam int c_LOCK_HOLD       = 65536;
    localparam int c_RELEASE_GAP     = 256;
    localparam int c_SOFT_RST_CYCLES = 1024;
    localparam int c_TICK_DIV        = 50000;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Parameterised flop-chain synchroniser with synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_seq
// Description : PLL reset/lock sequencer releasing system then CPU reset,
//               with lock-loss recovery, soft CPU reset and a 1 kHz tick.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = c_SYNC_STAGES,
    parameter int PLL_RST_CYCLES  = c_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT    = c_LOCK_TIMEOUT,
    parameter int LOCK_HOLD       = c_LOCK_HOLD,
    parameter int RELEASE_GAP     = c_RELEASE_GAP,
    parameter int SOFT_RST_CYCLES = c_SOFT_RST_CYCLES,
    parameter int TICK_DIV        = c_TICK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       cpu_rst,
    output logic       ready,
    output logic [3:0] relock_count,
    output logic       tick_1k
);

    localparam int c_CNT_MAX = max_of(max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                             max_of(LOCK_HOLD, RELEASE_GAP)),
                                      SOFT_RST_CYCLES);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_DIV_W   = $clog2(TICK_DIV + 1);

    localparam logic [c_CNT_W-1:0] c_PLL_RST_LAST = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK edge that enters HOLD already consumed one high sample.
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST    = c_CNT_W'(LOCK_HOLD - 2);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST     = c_CNT_W'(RELEASE_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_SOFT_LAST    = c_CNT_W'(SOFT_RST_CYCLES - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST     = c_DIV_W'(TICK_DIV - 1);

    pll_seq_state_t     r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_DIV_W-1:0] r_div;
    logic               r_pll_rst;
    logic               r_sys_rst;
    logic               r_cpu_rst;
    logic               r_ready;
    logic [3:0]         r_relock_count;
    logic               r_tick;
    logic               w_lock_s;
    logic               w_lock_lost;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (w_lock_s)
    );

    assign w_lock_lost = !w_lock_s &&
                         ((r_state == RELEASE) || (r_state == RUN) || (r_state == SOFT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RESET_PLL;
            r_cnt          <= '0;
            r_pll_rst      <= 1'b1;
            r_sys_rst      <= 1'b1;
            r_cpu_rst      <= 1'b1;
            r_ready        <= 1'b0;
            r_relock_count <= 4'd0;
        end else if (w_lock_lost) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
            r_sys_rst <= 1'b1;
            r_cpu_rst <= 1'b1;
            r_ready   <= 1'b0;
            if (r_relock_count != 4'hF) begin
                r_relock_count <= r_relock_count + 4'd1;
            end
        end else begin
            case (r_state)
                RESET_PLL: begin
                    if (r_cnt == c_PLL_RST_LAST) begin
                        r_state   <= WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_state   <= RESET_PLL;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!w_lock_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        r_state   <= RELEASE;
                        r_cnt     <= '0;
                        r_sys_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_state   <= RUN;
                        r_cnt     <= '0;
                        r_cpu_rst <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                RUN: begin
                    if (soft_reset) begin
                        r_state   <= SOFT;
                        r_cnt     <= '0;
                        r_cpu_rst <= 1'b1;
                        r_ready   <= 1'b0;
                    end
                end
                SOFT: begin
                    // Further soft_reset pulses are deliberately not looked at here.
                    if (r_cnt == c_SOFT_LAST) begin
                        r_state   <= RUN;
                        r_cnt     <= '0;
                        r_cpu_rst <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= RESET_PLL;
                    r_cnt     <= '0;
                    r_pll_rst <= 1'b1;
                    r_sys_rst <= 1'b1;
                    r_cpu_rst <= 1'b1;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Housekeeping divider only counts while the system is out of reset.
    always_ff @(posedge clk) begin
        if (rst || r_sys_rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (r_div == c_DIV_LAST) begin
            r_div  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_div  <= r_div + c_DIV_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign pll_rst      = r_pll_rst;
    assign sys_rst      = r_sys_rst;
    assign cpu_rst      = r_cpu_rst;
    assign ready        = r_ready;
    assign relock_count = r_relock_count;
    assign tick_1k      = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_seq
// Description : Scoreboard bench for pll_reset_seq using shrunk timing values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       soft_reset;
    logic       pll_rst;
    logic       sys_rst;
    logic       cpu_rst;
    logic       ready;
    logic [3:0] relock_count;
    logic       tick_1k;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
    } ev_t;

    ev_t        ctl_q[$];
    int         tick_q[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev   = 'x;

    pll_reset_seq #(
        .SYNC_STAGES     (2),
        .PLL_RST_CYCLES  (4),
        .LOCK_TIMEOUT    (50),
        .LOCK_HOLD       (20),
        .RELEASE_GAP     (8),
        .SOFT_RST_CYCLES (6),
        .TICK_DIV        (10)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .soft_reset   (soft_reset),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .cpu_rst      (cpu_rst),
        .ready        (ready),
        .relock_count (relock_count),
        .tick_1k      (tick_1k)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // {pll_rst, sys_rst, cpu_rst, ready, relock_count}
    function automatic logic [7:0] mk(input logic p, input logic s, input logic c,
                                      input logic r, input int n);
        return {p, s, c, r, 4'(n)};
    endfunction

    task automatic push_ctl(input int c, input logic [7:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        ctl_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every change of the control outputs and every tick pulse is an event.
    always @(negedge clk) begin
        logic [7:0] cur;
        ev_t        e;
        int         tc;
        cur = {pll_rst, sys_rst, cpu_rst, ready, relock_count};
        if (cur !== prev) begin
            checks++;
            if (ctl_q.size() == 0) begin
                errors++;
                $display("FAIL ctl_unexpected cyc=%0d got=%b expected no change", cyc, cur);
            end else begin
                e = ctl_q.pop_front();
                if (e.cyc != cyc || e.vec !== cur) begin
                    errors++;
                    $display("FAIL ctl_event got cyc=%0d vec=%b expected cyc=%0d vec=%b",
                             cyc, cur, e.cyc, e.vec);
                end
            end
            prev = cur;
        end
        if (tick_1k !== 1'b0) begin
            checks++;
            if (tick_q.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected cyc=%0d got=%b expected 0", cyc, tick_1k);
            end else begin
                tc = tick_q.pop_front();
                if (tc != cyc || tick_1k !== 1'b1) begin
                    errors++;
                    $display("FAIL tick_event got cyc=%0d val=%b expected cyc=%0d val=1",
                             cyc, tick_1k, tc);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog cyc=%0d expected finish before 2000 cycles", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int n;
        rst        = 1'b1;
        pll_locked = 1'b0;
        soft_reset = 1'b0;

        // Power-up: lock arrives 30 cycles after reset release.
        push_ctl(1,  mk(1, 1, 1, 0, 0));
        push_ctl(7,  mk(0, 1, 1, 0, 0));
        push_ctl(55, mk(0, 0, 1, 0, 0));
        push_ctl(63, mk(0, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++) tick_q.push_back(65 + 10 * k);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(33);
        pll_locked = 1'b1;

        // Soft reset, with a second pulse landing inside SOFT.
        push_ctl(71, mk(0, 0, 1, 0, 0));
        push_ctl(77, mk(0, 0, 0, 1, 0));
        wait_cyc(70);
        soft_reset = 1'b1;
        wait_cyc(71);
        soft_reset = 1'b0;
        wait_cyc(73);
        soft_reset = 1'b1;
        wait_cyc(74);
        soft_reset = 1'b0;

        // Lock loss in RUN, then no lock: two timeout re-pulses.
        push_ctl(93,  mk(0, 1, 1, 0, 1));
        push_ctl(143, mk(1, 1, 1, 0, 1));
        push_ctl(147, mk(0, 1, 1, 0, 1));
        push_ctl(197, mk(1, 1, 1, 0, 1));
        push_ctl(201, mk(0, 1, 1, 0, 1));
        wait_cyc(90);
        pll_locked = 1'b0;

        // Glitchy lock: 10 high, 1 low, then high.
        push_ctl(243, mk(0, 0, 1, 0, 1));
        push_ctl(251, mk(0, 0, 0, 1, 1));
        for (int k = 0; k < 4; k++) tick_q.push_back(253 + 10 * k);
        wait_cyc(210);
        pll_locked = 1'b1;
        wait_cyc(220);
        pll_locked = 1'b0;
        wait_cyc(221);
        pll_locked = 1'b1;

        // 16 further lock losses, mostly during RELEASE; count saturates at 15.
        t0 = 285;
        for (int i = 0; i < 16; i++) begin
            n = (i + 2 > 15) ? 15 : i + 2;
            push_ctl(t0 + 3,  mk(0, 1, 1, 0, n));
            push_ctl(t0 + 25, mk(0, 0, 1, 0, n));
            wait_cyc(t0);
            pll_locked = 1'b0;
            wait_cyc(t0 + 3);
            pll_locked = 1'b1;
            t0 = t0 + 27;
        end

        // Run with ticks, then rst on the edge where a tick was due.
        push_ctl(723, mk(0, 0, 0, 1, 15));
        tick_q.push_back(725);
        tick_q.push_back(735);
        push_ctl(745, mk(1, 1, 1, 0, 0));
        push_ctl(750, mk(0, 1, 1, 0, 0));
        wait_cyc(744);
        rst        = 1'b1;
        pll_locked = 1'b0;
        wait_cyc(746);
        rst = 1'b0;
        wait_cyc(770);

        checks++;
        if (ctl_q.size() != 0) begin
            errors++;
            $display("FAIL ctl_leftover got %0d pending expected 0 (next cyc=%0d)",
                     ctl_q.size(), ctl_q[0].cyc);
        end
        checks++;
        if (tick_q.size() != 0) begin
            errors++;
            $display("FAIL tick_leftover got %0d pending expected 0 (next cyc=%0d)",
                     tick_q.size(), tick_q[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
